// File: rtl/hash_mem_interface_seg_if.sv
// Core-side bundle between the multi-segment RAM front end and the SHAKE256 core.
// It carries the message stream (front end -> core), the message/digest lengths,
// and the digest stream (core -> front end).
//   master : front end (drives message, lengths, digest ready)
//   slave  : SHAKE256 core (drives message ready, digest data/valid)
interface hash_mem_interface_seg_if #(
  parameter int IO_WIDTH = 32,
  parameter int LEN_W    = 32
);
  logic [IO_WIDTH-1:0] hash_in;
  logic                hash_in_valid;
  logic                hash_in_last;
  logic                hash_in_ready;
  logic [LEN_W-1:0]    hash_in_len;
  logic [LEN_W-1:0]    hash_out_len;
  logic [IO_WIDTH-1:0] hash_out;
  logic                hash_out_valid;
  logic                hash_out_ready;

  modport master (
    output hash_in, hash_in_valid, hash_in_last, hash_in_len, hash_out_len, hash_out_ready,
    input  hash_in_ready, hash_out, hash_out_valid
  );

  modport slave (
    input  hash_in, hash_in_valid, hash_in_last, hash_in_len, hash_out_len, hash_out_ready,
    output hash_in_ready, hash_out, hash_out_valid
  );
endinterface

// File: rtl/hash_mem_interface_seg.sv
// Multi-segment RAM-to-SHAKE256 front end.
// Gathers the message from up to NUM_SEG RAM regions, streams it to the core with
// ready/valid, then forwards the digest to the consumer truncated to the requested
// length. The last word of each stream has its unused upper bits forced to zero.
// Optional build macro HASH_MEM_DOMAIN_SEP_EN adds port i_dsep, sent as the first
// message word (counted in the message length).
// Ports:
//   clk, rst (async, active low)
//   i_start, i_seg_base, i_seg_len, i_output_length : job setup (sampled in IDLE)
//   o_rd_en, o_addr, i_data_in                      : RAM read port (RD_LATENCY cycles)
//   core                                            : message/digest streams to the core
//   o_data_out, o_data_out_valid, i_data_out_ready  : digest stream to consumer
//   o_busy, o_done                                  : status
//
// state   | meaning
// S_IDLE  | waiting for i_start
// S_LOAD  | job parameters latched, segment walk initialised
// S_READ  | issuing RAM reads segment by segment
// S_DRAIN | all reads issued, emptying FIFO to the core
// S_EMPTY | empty message: one zero word with last=1
// S_OUT   | forwarding digest words to the consumer
// S_DONE  | o_done pulse
module hash_mem_interface_seg #(
  parameter int IO_WIDTH      = 32,
  parameter int MAX_RAM_DEPTH = 64,
  parameter int NUM_SEG       = 2,
  parameter int RD_LATENCY    = 1,
  parameter int LEN_W         = 32,
  localparam int ADDR_W       = $clog2(MAX_RAM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [NUM_SEG*ADDR_W-1:0] i_seg_base,
  input  logic [NUM_SEG*LEN_W-1:0]  i_seg_len,
  input  logic [LEN_W-1:0]          i_output_length,
  output logic                      o_rd_en,
  output logic [ADDR_W-1:0]         o_addr,
  input  logic [IO_WIDTH-1:0]       i_data_in,
  hash_mem_interface_seg_if.master  core,
  output logic [IO_WIDTH-1:0]       o_data_out,
  output logic                      o_data_out_valid,
  input  logic                      i_data_out_ready,
`ifdef HASH_MEM_DOMAIN_SEP_EN
  input  logic [IO_WIDTH-1:0]       i_dsep,
`endif
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int FIFO_D = RD_LATENCY + 1;
  localparam int PTR_W  = $clog2(FIFO_D);
  localparam int OCC_W  = PTR_W + 1;
  localparam int SEG_W  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
`ifdef HASH_MEM_DOMAIN_SEP_EN
  localparam logic [LEN_W-1:0] DSEP_BITS = LEN_W'(IO_WIDTH);
`else
  localparam logic [LEN_W-1:0] DSEP_BITS = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READ, S_DRAIN, S_EMPTY, S_OUT, S_DONE
  } state_t;

  function automatic logic [LEN_W-1:0] ceil_words(input logic [LEN_W-1:0] bits);
    logic [LEN_W:0] t;
    t = {1'b0, bits} + (LEN_W+1)'(IO_WIDTH - 1);
    t = t / (LEN_W+1)'(IO_WIDTH);
    return t[LEN_W-1:0];
  endfunction

  // Keeps the low (bits mod IO_WIDTH) bits; all ones when the remainder is zero.
  function automatic logic [IO_WIDTH-1:0] tail_mask(input logic [LEN_W-1:0] bits);
    logic [LEN_W-1:0]    rem;
    logic [IO_WIDTH-1:0] m;
    rem = bits % LEN_W'(IO_WIDTH);
    for (int i = 0; i < IO_WIDTH; i++) m[i] = (rem == '0) || (LEN_W'(i) < rem);
    return m;
  endfunction

  state_t                    state_q, state_d;
  logic [NUM_SEG*ADDR_W-1:0] base_q, base_d;
  logic [NUM_SEG*LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]          out_len_q, out_len_d;
  logic [LEN_W-1:0]          total_q, total_d;
  logic [LEN_W-1:0]          msg_words_q, msg_words_d;
  logic [LEN_W-1:0]          out_words_q, out_words_d;
  logic [SEG_W-1:0]          seg_q, seg_d;
  logic [LEN_W-1:0]          word_idx_q, word_idx_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [LEN_W-1:0]          msg_cnt_q, msg_cnt_d;
  logic [LEN_W-1:0]          out_cnt_q, out_cnt_d;
  logic [RD_LATENCY-1:0]     pipe_q, pipe_d;
  logic [IO_WIDTH-1:0]       fifo_mem_q [FIFO_D];
  logic [IO_WIDTH-1:0]       fifo_mem_d [FIFO_D];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]          occ_q, occ_d;
`ifdef HASH_MEM_DOMAIN_SEP_EN
  logic [IO_WIDTH-1:0]       dsep_q, dsep_d;
`endif

  logic [LEN_W-1:0]    len_sum;
  logic [LEN_W-1:0]    cur_len;
  logic [LEN_W-1:0]    cur_words;
  logic                seg_last;
  logic [ADDR_W-1:0]   next_base;
  logic [ADDR_W-1:0]   addr_inc;
  int                  outstanding;
  logic                msg_valid, msg_last, msg_hs, fifo_pop;
  logic [IO_WIDTH-1:0] msg_data;
  logic                out_act, out_last, out_hs;
  logic                issue, advance, push;
  logic [IO_WIDTH-1:0] push_data;

  always_comb begin
    len_sum = '0;
    for (int k = 0; k < NUM_SEG; k++) len_sum = len_sum + i_seg_len[k*LEN_W +: LEN_W];
  end

  always_comb begin
    cur_len   = len_q[int'(seg_q)*LEN_W +: LEN_W];
    cur_words = ceil_words(cur_len);
    seg_last  = (seg_q == SEG_W'(NUM_SEG - 1));
    next_base = seg_last ? '0 : base_q[(int'(seg_q) + 1)*ADDR_W +: ADDR_W];
    addr_inc  = (addr_q == ADDR_W'(MAX_RAM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
  end

  // Reads in flight, counted against FIFO space so backpressure never drops a word.
  always_comb begin
    outstanding = 0;
    for (int i = 0; i < RD_LATENCY; i++) outstanding += int'(pipe_q[i]);
  end

  always_comb begin
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_data  = '0;
    case (state_q)
      S_READ, S_DRAIN: begin
        msg_valid = (occ_q != '0);
        msg_last  = msg_valid && (msg_cnt_q == msg_words_q - LEN_W'(1));
        if (msg_valid)
          msg_data = fifo_mem_q[rd_ptr_q] & (msg_last ? tail_mask(total_q) : '1);
      end
      S_EMPTY: begin
        msg_valid = 1'b1;
        msg_last  = 1'b1;
      end
      default: ;
    endcase
    msg_hs   = msg_valid && core.hash_in_ready;
    fifo_pop = msg_hs && (state_q != S_EMPTY);
  end

  always_comb begin
    out_act  = (state_q == S_OUT);
    out_last = (out_cnt_q == out_words_q - LEN_W'(1));
    out_hs   = out_act && core.hash_out_valid && i_data_out_ready;
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    out_len_d   = out_len_q;
    total_d     = total_q;
    msg_words_d = msg_words_q;
    out_words_d = out_words_q;
    seg_d       = seg_q;
    word_idx_d  = word_idx_q;
    addr_d      = addr_q;
    msg_cnt_d   = msg_cnt_q;
    out_cnt_d   = out_cnt_q;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    issue       = 1'b0;
    advance     = 1'b0;
    push        = pipe_q[RD_LATENCY-1];
    push_data   = i_data_in;
`ifdef HASH_MEM_DOMAIN_SEP_EN
    dsep_d      = dsep_q;
    if (state_q == S_LOAD) begin
      push      = 1'b1;
      push_data = dsep_q;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_LOAD;
          base_d      = i_seg_base;
          len_d       = i_seg_len;
          out_len_d   = i_output_length;
          total_d     = len_sum + DSEP_BITS;
          msg_words_d = ceil_words(len_sum + DSEP_BITS);
          out_words_d = ceil_words(i_output_length);
`ifdef HASH_MEM_DOMAIN_SEP_EN
          dsep_d      = i_dsep;
`endif
        end
      end
      S_LOAD: begin
        seg_d      = '0;
        word_idx_d = '0;
        addr_d     = base_q[ADDR_W-1:0];
        msg_cnt_d  = '0;
        out_cnt_d  = '0;
        state_d    = (total_q == '0) ? S_EMPTY : S_READ;
      end
      S_READ: begin
        if (cur_words == '0) begin
          advance = 1'b1;
        end else if ((int'(occ_q) + outstanding - int'(fifo_pop)) < FIFO_D) begin
          issue = 1'b1;
          if (word_idx_q == cur_words - LEN_W'(1)) begin
            advance = 1'b1;
          end else begin
            word_idx_d = word_idx_q + LEN_W'(1);
            addr_d     = addr_inc;
          end
        end
        if (advance) begin
          if (seg_last) begin
            state_d = S_DRAIN;
          end else begin
            seg_d      = seg_q + SEG_W'(1);
            word_idx_d = '0;
            addr_d     = next_base;
          end
        end
      end
      S_DRAIN, S_EMPTY: ;
      S_OUT: begin
        if (out_hs) begin
          out_cnt_d = out_cnt_q + LEN_W'(1);
          if (out_last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The final message handshake ends the message phase from whichever state it occurs in.
    if (msg_hs) begin
      msg_cnt_d = msg_cnt_q + LEN_W'(1);
      if (msg_last) state_d = (out_words_q == '0) ? S_DONE : S_OUT;
    end

    if (push) begin
      fifo_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    occ_d = occ_q + OCC_W'(push) - OCC_W'(fifo_pop);

    pipe_d[0] = issue;
    for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      out_len_q   <= '0;
      total_q     <= '0;
      msg_words_q <= '0;
      out_words_q <= '0;
      seg_q       <= '0;
      word_idx_q  <= '0;
      addr_q      <= '0;
      msg_cnt_q   <= '0;
      out_cnt_q   <= '0;
      pipe_q      <= '0;
      for (int i = 0; i < FIFO_D; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
`ifdef HASH_MEM_DOMAIN_SEP_EN
      dsep_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      out_len_q   <= out_len_d;
      total_q     <= total_d;
      msg_words_q <= msg_words_d;
      out_words_q <= out_words_d;
      seg_q       <= seg_d;
      word_idx_q  <= word_idx_d;
      addr_q      <= addr_d;
      msg_cnt_q   <= msg_cnt_d;
      out_cnt_q   <= out_cnt_d;
      pipe_q      <= pipe_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
`ifdef HASH_MEM_DOMAIN_SEP_EN
      dsep_q      <= dsep_d;
`endif
    end
  end

  assign o_rd_en             = issue;
  assign o_addr              = addr_q;
  assign core.hash_in        = msg_data;
  assign core.hash_in_valid  = msg_valid;
  assign core.hash_in_last   = msg_last;
  assign core.hash_in_len    = total_q;
  assign core.hash_out_len   = out_len_q;
  assign core.hash_out_ready = out_act && i_data_out_ready;
  assign o_data_out_valid    = out_act && core.hash_out_valid;
  assign o_data_out          = (out_act && core.hash_out_valid)
                               ? (core.hash_out & (out_last ? tail_mask(out_len_q) : '1)) : '0;
  assign o_busy              = (state_q != S_IDLE);
  assign o_done              = (state_q == S_DONE);

endmodule
